button_debouncer: RTL
=====================

Name: button_debouncer

Overview:
- Front-end conditioning stage for the player controls. Sits directly upstream of the input collector and drives its up/down/left/right/attack inputs.
- Synchronises asynchronous pad/controller button lines into the clk domain and filters contact bounce per button.
- Presents clean, glitch-free levels plus one-cycle press/release strobes for debug and other consumers.

Parameters:
- NUM_BUTTONS, 5, number of button channels. Bit order: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 ACTION.
- SYNC_STAGES, 2, synchroniser flop depth. Minimum 2.
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before an accepted change. Minimum 2.
- CNT_WIDTH, 16, counter width. Must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 0, set to 1 when pads read 0 while pressed. Inversion happens after synchronisation.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-low reset.
- btn_raw, input, NUM_BUTTONS, raw asynchronous button lines.
- btn_clean, output, NUM_BUTTONS, debounced level. 1 = pressed.
- btn_press, output, NUM_BUTTONS, one-cycle strobe on the cycle btn_clean rises.
- btn_release, output, NUM_BUTTONS, one-cycle strobe on the cycle btn_clean falls.

Behaviour:
- Reset:
  - Clock clk; reset reset, synchronous, active-low.
  - While reset==0 at a clk edge: all sync flops load the inactive pad level (0, or 1 if ACTIVE_LOW), all FSMs go to STABLE_LOW, all counters 0.
  - btn_clean, btn_press and btn_release are all 0.
- Synchroniser: SYNC_STAGES-deep flop chain per bit. Its output, after optional inversion, is s[i].
- Per-channel FSM (independent per bit), states STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW:
  - STABLE_LOW: s==1 -> PEND_HIGH, cnt<=1. Otherwise stay, cnt<=0.
  - PEND_HIGH:
    - s==0 -> STABLE_LOW, cnt<=0 (glitch rejected, no output change).
    - s==1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, btn_clean<=1, btn_press<=1, cnt<=0.
    - Else cnt<=cnt+1.
  - STABLE_HIGH and PEND_LOW: mirror of the above with polarity inverted; the exit from PEND_LOW sets btn_clean<=0 and btn_release<=1.
- Latency: if raw is stable from just before edge 1, btn_clean changes after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Glitch filtering: any excursion of s shorter than DEBOUNCE_CYCLES cycles produces no output change and no strobe.
- Strobes: btn_press and btn_release are registered and high for exactly one cycle, aligned with the btn_clean transition. They return to 0 on the next cycle.
- press and release for the same bit are never asserted together. Different bits may strobe in the same cycle.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1, so no wrap-around can occur.
- Reset mid-pending: the pending count is discarded and no strobe is emitted. After reset release, a held button requires a full SYNC_STAGES+DEBOUNCE_CYCLES qualification.
- Holding a button indefinitely leaves btn_clean=1 with no further strobes.

Decomposition:
- Shared package holds:
  - Button index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_ACTION=4, and NUM_BUTTONS=5.
  - The 2-bit debounce state encoding (STABLE_LOW=0, PEND_HIGH=1, STABLE_HIGH=2, PEND_LOW=3).
- Sub-module debounce_channel: one synchroniser, FSM and counter for a single bit. The top instantiates NUM_BUTTONS copies via generate.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=0):
- Reset: hold reset=0 for 3 cycles with btn_raw=5'b11111 -> all outputs 0 throughout. After release, outputs stay 0 until edge 6.
- Clean press: btn_raw[0] 0->1, held -> btn_clean[0]=1 after edge 6 (SYNC_STAGES+DEBOUNCE_CYCLES), btn_press[0]=1 for that single cycle, btn_release=0.
- Glitch rejection: btn_raw[4] high for 3 cycles then low -> btn_clean, btn_press and btn_release all stay 0. A pulse of 4+ cycles is accepted.
- Bounce train: btn_raw[2] toggles 1,0,1,1,0,1 then holds 1 -> exactly one btn_press[2] strobe, 6 cycles after the final 0->1 edge. Then drop and hold 0 -> exactly one btn_release[2] strobe 6 cycles later.
- Simultaneous buttons: btn_raw 5'b00000->5'b01011 in one cycle -> btn_clean=5'b01011 and btn_press=5'b01011 in the same single cycle.
- Reset mid-pending plus polarity: assert reset=0 on cycle 3 of a PEND_HIGH count -> no strobe, counter cleared. Separately, ACTIVE_LOW=1 with btn_raw[1] driven 1->0 -> btn_clean[1] rises 6 cycles later.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - button indices and debounce state encoding
package button_debouncer_pkg;

  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_LEFT    = 2;
  localparam int BTN_RIGHT   = 3;
  localparam int BTN_ACTION  = 4;
  localparam int NUM_BUTTONS = 5;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    PEND_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    PEND_LOW    = 2'd3
  } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchroniser, debounce FSM and counter for one button
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_clean,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  deb_state_e             r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_clean;
  logic                   r_press;
  logic                   r_release;
  logic                   w_s;

  // Reset loads the idle pad level so releasing reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (!reset) r_sync <= {SYNC_STAGES{ACTIVE_LOW}};
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
  end

  assign w_s = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= STABLE_LOW;
      r_cnt     <= '0;
      r_clean   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        STABLE_LOW: begin
          if (w_s) begin
            r_state <= PEND_HIGH;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt <= '0;
          end
        end
        PEND_HIGH: begin
          if (!w_s) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_HIGH;
            r_clean <= 1'b1;
            r_press <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!w_s) begin
            r_state <= PEND_LOW;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt <= '0;
          end
        end
        PEND_LOW: begin
          if (w_s) begin
            r_state <= STABLE_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= STABLE_LOW;
            r_clean   <= 1'b0;
            r_release <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= STABLE_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign btn_clean   = r_clean;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-button synchronise and debounce with press/release strobes
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int NUM_BUTTONS     = button_debouncer_pkg::NUM_BUTTONS,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_clean,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release
);

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw[g]),
      .btn_clean   (btn_clean[g]),
      .btn_press   (btn_press[g]),
      .btn_release (btn_release[g])
    );
  end

endmodule
